// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV64 subset sequencer.
// Opcode constants are also consumed by the immediate generator.
package ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_LD,
    BRANCH,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_ILLEGAL     = 2'b01,
    CAUSE_MEM_TIMEOUT = 2'b10
  } trap_cause_e;

  // States that own the shared memory port.
  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles; flags expiry on the cycle the count reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A stalled cycle that takes the count to MEM_TIMEOUT; a transfer keeps count_en low.
  assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a shared memory port and trap handling.
// Define CTRL_PERF_EN to build the 32-bit retired-instruction counter; otherwise instret is 0.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic        mem_to_reg,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  alu_op_e     alu_op_w;
  logic        transfer;
  logic        timer_expired;

  assign transfer = mem_req && mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!is_mem_state(state_q) || transfer),
    .count_en(mem_req && !mem_ready),
    .expired (timer_expired)
  );

  // Outputs decode from the registered state only; mem_ready/alu_zero qualify the PC/IR strobes.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    alu_src_b   = 1'b0;
    alu_op_w    = ALU_ADD;
    rf_we       = 1'b0;
    mem_to_reg  = 1'b0;
    trap        = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      EXEC_R:    alu_op_w = ALU_FUNCT;
      EXEC_ADDR: alu_src_b = 1'b1;
      MEM_RD: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
      end
      MEM_WR: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = 1'b1;
      end
      WB_ALU: rf_we = 1'b1;
      WB_LD: begin
        rf_we      = 1'b1;
        mem_to_reg = 1'b1;
      end
      BRANCH: begin
        alu_op_w = ALU_SUB;
        pc_we    = alu_zero;
        pc_src   = 1'b1;
      end
      TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign alu_op     = alu_op_w;
  assign trap_cause = cause_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (transfer) state_d = DECODE;
      DECODE: begin
        if (opcode == OPC_RTYPE) begin
          state_d = EXEC_R;
        end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          state_d = EXEC_ADDR;
        end else if (opcode == OPC_BRANCH) begin
          state_d = BRANCH;
        end else begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      EXEC_R:    state_d = WB_ALU;
      EXEC_ADDR: state_d = (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:    if (transfer) state_d = WB_LD;
      MEM_WR:    if (transfer) state_d = FETCH;
      WB_ALU:    state_d = FETCH;
      WB_LD:     state_d = FETCH;
      BRANCH:    state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = IDLE;
    endcase
    // Stalled request overrides the hold in any memory state.
    if (timer_expired) begin
      state_d = TRAP;
      cause_d = CAUSE_MEM_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (state_q == WB_ALU) || (state_q == WB_LD) || (state_q == BRANCH) ||
                  ((state_q == MEM_WR) && transfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm: per-instruction expectations from latency/strobe rules.
module tb_mc_ctrl_fsm;

  localparam int TO = 4;
  localparam int K_R = 0, K_LD = 1, K_SD = 2, K_BEQ = 3, K_ILL = 4;
`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        alu_zero, mem_ready;
  logic        mem_req, mem_we, mem_is_data, ir_we, pc_we, pc_src, alu_src_b;
  logic [1:0]  alu_op;
  logic        rf_we, mem_to_reg, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_data(mem_is_data), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .rf_we(rf_we), .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc, rf, ldwb, pcw, pcs, irw, dwr, drd, nf, ns, na, cause;
    int unsigned ret;
  } exp_t;

  exp_t        q[$];
  exp_t        acc;
  int          tests = 0;
  int          errors = 0;
  int unsigned model_ret = 0;
  bit          open_r = 1'b0;
  bit          prevf = 1'b0;
  bit          fstart = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-instruction footprint from the latency and strobe rules.
  function automatic exp_t model(input int kind, input int fw, input int dw, input bit z);
    exp_t e;
    int   n;
    e = '{default: 0};
    e.kind = kind;
    if (fw >= TO) begin
      e.cyc   = TO;
      e.cause = 2;
      return e;
    end
    e.irw = 1;
    e.pcw = 1;
    case (kind)
      K_ILL: begin e.cyc = fw + 2; e.cause = 1; end
      K_R:   begin e.cyc = fw + 4; e.nf = 1; e.rf = 1; end
      K_BEQ: begin e.cyc = fw + 3; e.ns = 1; e.pcw += int'(z); e.pcs = int'(z); end
      default: begin
        e.na = 1;
        if (dw >= TO) begin
          e.cyc   = fw + 3 + TO;
          e.cause = 2;
          n       = TO;
        end else begin
          e.cyc = fw + 4 + dw + ((kind == K_LD) ? 1 : 0);
          n     = dw + 1;
          if (kind == K_LD) begin e.rf = 1; e.ldwb = 1; end
        end
        if (kind == K_LD) e.drd = n;
        else e.dwr = n;
      end
    endcase
    return e;
  endfunction

  function automatic logic [6:0] opc_of(input int kind);
    logic [6:0] v;
    case (kind)
      K_R:   v = 7'h33;
      K_LD:  v = 7'h03;
      K_SD:  v = 7'h23;
      K_BEQ: v = 7'h63;
      default: begin
        do v = 7'($urandom_range(0, 127));
        while (v == 7'h33 || v == 7'h03 || v == 7'h23 || v == 7'h63);
      end
    endcase
    return v;
  endfunction

  task automatic close_rec();
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      errors++;
      $display("FAIL scoreboard: instruction ended with empty queue, got 0 entries, required 1");
      return;
    end
    e = q.pop_front();
    chk("cycles", acc.cyc, e.cyc);
    chk("rf_we_cycles", acc.rf, e.rf);
    chk("load_wb", acc.ldwb, e.ldwb);
    chk("pc_we_cycles", acc.pcw, e.pcw);
    chk("pc_branch", acc.pcs, e.pcs);
    chk("ir_we_cycles", acc.irw, e.irw);
    chk("data_wr_cycles", acc.dwr, e.dwr);
    chk("data_rd_cycles", acc.drd, e.drd);
    chk("alu_funct", acc.nf, e.nf);
    chk("alu_sub", acc.ns, e.ns);
    chk("alu_addr", acc.na, e.na);
    chk("trap_cause", trap_cause, e.cause);
    chk("instret", instret, e.ret);
    $display("[TB] instr kind=%0d cycles=%0d rf_we=%0d cause=%0d instret=%0d",
             e.kind, acc.cyc, acc.rf, trap_cause, instret);
  endtask

  // Monitor: bounds each instruction by fetch starts / trap entry and accumulates strobes.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        open_r = 1'b0;
        prevf  = 1'b0;
      end else begin
        fstart = mem_req && !mem_is_data && !prevf;
        prevf  = mem_req && !mem_is_data;
        if (open_r && (fstart || trap)) begin
          close_rec();
          open_r = 1'b0;
        end
        if (fstart) begin
          open_r = 1'b1;
          acc    = '{default: 0};
        end
        if (open_r) begin
          acc.cyc++;
          acc.rf   += int'(rf_we);
          acc.ldwb += int'(rf_we && mem_to_reg);
          acc.pcw  += int'(pc_we);
          acc.pcs  += int'(pc_we && pc_src);
          acc.irw  += int'(ir_we);
          acc.dwr  += int'(mem_req && mem_is_data && mem_we);
          acc.drd  += int'(mem_req && mem_is_data && !mem_we);
          acc.nf   += int'(alu_op == 2'b10);
          acc.ns   += int'(alu_op == 2'b01);
          acc.na   += int'(alu_src_b && alu_op == 2'b00);
        end
      end
    end
  end

  task automatic do_reset();
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_enables", {mem_we, mem_is_data, ir_we, pc_we, rf_we, mem_to_reg}, 0);
    chk("rst_trap", {trap, trap_cause}, 0);
    chk("rst_instret", instret, 0);
    q.delete();
    model_ret = 0;
    step();
    rst = 1'b0;
    chk("idle_mem_req", mem_req, 0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (mem_req) begin
        ok = 1'b1;
        return;
      end
      mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    tests++;
    errors++;
    $display("FAIL wait_req: mem_req got 0 for 16 cycles, required 1");
  endtask

  task automatic serve(input int w);
    for (int i = 0; i < w; i++) begin
      mem_ready = 1'b0;
      step();
      if (!mem_req) return;
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic hold_trap(input int cause);
    int k = 0;
    while (!trap && k < 8) begin
      mem_ready = 1'b0;
      step();
      k++;
    end
    chk("trap_entry", trap, 1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      chk("trap_hold", trap, 1);
      chk("trap_mem_req", mem_req, 0);
      chk("trap_cause_hold", trap_cause, cause);
      chk("trap_enables", {rf_we, pc_we, ir_we}, 0);
      step();
    end
  endtask

  task automatic run_instr(input int kind, input int fw, input int dw, input bit z,
                           input bit abort, input int force_opc);
    exp_t e;
    bit   ok;
    wait_req(ok);
    if (!ok) begin do_reset(); return; end
    opcode   = (force_opc >= 0) ? 7'(force_opc) : opc_of(kind);
    alu_zero = z;
    e = model(kind, fw, dw, z);
    if (e.cause == 0) model_ret++;
    e.ret = PERF ? model_ret : 32'd0;
    q.push_back(e);
    serve(fw);
    if ((kind == K_LD || kind == K_SD) && fw < TO) begin
      wait_req(ok);
      if (!ok) begin do_reset(); return; end
      chk("data_is_data", mem_is_data, 1);
      chk("data_we", mem_we, (kind == K_SD) ? 1 : 0);
      if (abort) begin
        do_reset();
        return;
      end
      serve(dw);
    end
    if (e.cause != 0) begin
      hold_trap(e.cause);
      do_reset();
    end
  endtask

  initial begin
    bit ok;
    int r, kind, fw, dw;
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 7'h0;
    alu_zero  = 1'b0;
    #2;
    do_reset();
    run_instr(K_R,   0, 0, 1'b0, 1'b0, 7'h33);
    run_instr(K_LD,  0, 3, 1'b0, 1'b0, 7'h03);
    run_instr(K_SD,  0, 0, 1'b0, 1'b0, 7'h23);
    run_instr(K_BEQ, 0, 0, 1'b1, 1'b0, -1);
    run_instr(K_BEQ, 1, 0, 1'b0, 1'b0, -1);
    run_instr(K_ILL, 0, 0, 1'b0, 1'b0, 7'h13);
    run_instr(K_R,   TO, 0, 1'b0, 1'b0, -1);
    run_instr(K_R,   TO - 1, 0, 1'b0, 1'b0, -1);
    run_instr(K_SD,  0, TO - 1, 1'b0, 1'b0, -1);
    run_instr(K_LD,  2, TO, 1'b0, 1'b0, -1);
    run_instr(K_R,   0, 0, 1'b0, 1'b0, -1);
    run_instr(K_SD,  1, 0, 1'b0, 1'b1, -1);
    run_instr(K_R,   0, 0, 1'b0, 1'b0, -1);
    run_instr(K_BEQ, 0, 0, 1'b1, 1'b0, -1);
    run_instr(K_SD,  0, 1, 1'b0, 1'b0, -1);
    for (int n = 0; n < 250; n++) begin
      r    = int'($urandom_range(0, 99));
      kind = (r < 28) ? K_R : (r < 52) ? K_LD : (r < 74) ? K_SD : (r < 95) ? K_BEQ : K_ILL;
      fw   = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, 3));
      dw   = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, 3));
      run_instr(kind, fw, dw, 1'($urandom_range(0, 1)),
                (kind == K_SD) && ($urandom_range(0, 15) == 0), -1);
    end
    wait_req(ok);
    step();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
